inst_fetch_stage: RTL

Instruction-fetch stage of the MIPS datapath: owns the program counter, drives the instruction memory's `Pc` input, and captures the returned `InstReg` word into the IF/ID pipeline register. It selects the next PC from sequential, branch and jump sources. It also handles stall, flush and halt, and sits directly upstream of the instruction memory and the decode stage.

---
 rtl/inst_fetch_stage.sv | 96 +++++++++
 1 files changed

// File: rtl/inst_fetch_stage.sv
// inst_fetch_stage: MIPS IF stage owning the PC and the IF/ID register; optional syscall halt under IFETCH_HALT_DETECT_EN
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] InstReg,
  output logic [31:0] Pc,
  output logic [31:0] IfId_Inst,
  output logic [31:0] IfId_PcPlus4,
  output logic        IfId_Valid,
  output logic        Halted,
  output logic        MisalignErr
);
  localparam logic [31:0] ADDR_MASK = 32'(IMEM_WORDS * 4 - 1);
  typedef enum logic [1:0] {S_RESET, S_RUN, S_HALT} state_t;
  state_t      r_state;
  logic [31:0] r_pc, r_inst, r_pc_plus4;
  logic        r_valid, r_misalign;
  logic [31:0] w_pc_plus4, w_target, w_next_pc;
  logic        w_redirect, w_kill;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redirect = Jump | BranchTaken;
  assign w_kill     = Flush | w_redirect;
  assign w_target   = Jump ? {w_pc_plus4[31:28], JumpIndex, 2'b00} : {BranchTarget[31:2], 2'b00};
  assign w_next_pc  = (w_redirect ? w_target : Stall ? r_pc : w_pc_plus4) & ADDR_MASK;
`ifdef IFETCH_HALT_DETECT_EN
  logic r_halted;
  assign Halted = r_halted;
`else
  assign Halted = 1'b0;
`endif
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_RESET;
      r_pc       <= RESET_PC;
      r_inst     <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
`ifdef IFETCH_HALT_DETECT_EN
      r_halted   <= 1'b0;
`endif
    end else begin
      if (r_state != S_RESET && BranchTaken && |BranchTarget[1:0]) r_misalign <= 1'b1;
      case (r_state)
        // first edge out of reset only arms fetch so IMEM[RESET_PC] gets a full cycle
        S_RESET: r_state <= S_RUN;
        S_RUN: begin
          r_pc <= w_next_pc;
          if (w_kill) begin
            r_inst     <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
          end else if (!Stall) begin
            r_inst     <= InstReg;
            r_pc_plus4 <= w_pc_plus4 & ADDR_MASK;
            r_valid    <= 1'b1;
`ifdef IFETCH_HALT_DETECT_EN
            if (InstReg == 32'h0000_000C) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
`endif
          end
        end
`ifdef IFETCH_HALT_DETECT_EN
        // halted fetch only leaves on a redirect, meaning the syscall was wrong-path
        S_HALT: begin
          r_inst     <= '0;
          r_pc_plus4 <= '0;
          r_valid    <= 1'b0;
          if (w_redirect) begin
            r_pc     <= w_next_pc;
            r_state  <= S_RUN;
            r_halted <= 1'b0;
          end
        end
`endif
        default: r_state <= S_RUN;
      endcase
    end
  end
  assign Pc           = r_pc;
  assign IfId_Inst    = r_inst;
  assign IfId_PcPlus4 = r_pc_plus4;
  assign IfId_Valid   = r_valid;
  assign MisalignErr  = r_misalign;
endmodule
